// File: rtl/alu_uart_ctrl.sv
// alu_uart_ctrl: collects a three-byte frame (operand A, operand B, opcode) from a UART receiver.
// It drives the operands to an external combinational ALU and transmits the one-byte result.
//
// Parameters:
//   DATA_WIDTH    - width of operands, result and UART bytes
//   OP_WIDTH      - opcode width, taken from the LSBs of the op byte
//   TIMEOUT_TICKS - i_tick pulses allowed between frame bytes (only with ALU_UART_TIMEOUT_EN)
//
// Ports:
//   i_clock, i_reset       - clock and asynchronous active-high reset
//   i_tick                 - baud tick, used only by the inter-byte timeout
//   i_rx_done, i_rx_data   - received byte strobe and data
//   i_alu_result           - combinational ALU result for o_alu_a/b/op
//   i_tx_done              - transmitter frame-complete pulse
//   o_alu_a/b/op           - captured operands and opcode
//   o_tx_start, o_tx_data  - one-cycle transmit request and the byte to send
//   o_busy                 - high while a frame is in progress
//   o_overrun              - sticky, a byte arrived while not accepting
//   o_timeout              - one-cycle pulse when a partial frame is abandoned
//
// Build option: define ALU_UART_TIMEOUT_EN to enable the inter-byte timeout.
// Without it the FSM waits forever for the next byte and o_timeout stays 0.

module alu_uart_ctrl #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned OP_WIDTH      = 6,
  parameter int unsigned TIMEOUT_TICKS = 2560
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_tick,
  input  logic                  i_rx_done,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic [DATA_WIDTH-1:0] i_alu_result,
  input  logic                  i_tx_done,
  output logic [DATA_WIDTH-1:0] o_alu_a,
  output logic [DATA_WIDTH-1:0] o_alu_b,
  output logic [OP_WIDTH-1:0]   o_alu_op,
  output logic                  o_tx_start,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic                  o_busy,
  output logic                  o_overrun,
  output logic                  o_timeout
);

  typedef enum logic [2:0] {
    StIdleA  = 3'd0,
    StWaitB  = 3'd1,
    StWaitOp = 3'd2,
    StSend   = 3'd3,
    StWaitTx = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d;
  logic [DATA_WIDTH-1:0] alu_b_q, alu_b_d;
  logic [OP_WIDTH-1:0]   alu_op_q, alu_op_d;
  logic                  tx_start_q, tx_start_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  overrun_q, overrun_d;
  logic                  timeout_q, timeout_d;

`ifdef ALU_UART_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_TICKS + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tick_expire;

  // The tick that brings the count up to TIMEOUT_TICKS abandons the frame.
  assign tick_expire = i_tick && (cnt_q == CntW'(TIMEOUT_TICKS - 1));
`else
  logic unused_tick;
  assign unused_tick = i_tick;
`endif

  always_comb begin
    state_d    = state_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    overrun_d  = overrun_q;
    timeout_d  = 1'b0;
`ifdef ALU_UART_TIMEOUT_EN
    cnt_d      = '0;
`endif

    unique case (state_q)
      StIdleA: begin
        if (i_rx_done) begin
          alu_a_d = i_rx_data;
          state_d = StWaitB;
        end
      end
      StWaitB, StWaitOp: begin
        if (i_rx_done) begin
          if (state_q == StWaitB) begin
            alu_b_d = i_rx_data;
            state_d = StWaitOp;
          end else begin
            alu_op_d = i_rx_data[OP_WIDTH-1:0];
            state_d  = StSend;
          end
`ifdef ALU_UART_TIMEOUT_EN
        end else if (tick_expire) begin
          // Captured operands are kept; only the frame position is dropped.
          state_d   = StIdleA;
          timeout_d = 1'b1;
        end else if (i_tick) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = cnt_q;
`endif
        end
      end
      StSend: begin
        // One cycle for the ALU to settle on the newly captured opcode.
        tx_data_d  = i_alu_result;
        tx_start_d = 1'b1;
        state_d    = StWaitTx;
        if (i_rx_done) overrun_d = 1'b1;
      end
      StWaitTx: begin
        if (i_rx_done) overrun_d = 1'b1;
        if (i_tx_done) state_d = StIdleA;
      end
      default: state_d = StIdleA;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= StIdleA;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      overrun_q  <= overrun_d;
      timeout_q  <= timeout_d;
    end
  end

`ifdef ALU_UART_TIMEOUT_EN
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`endif

  assign o_alu_a    = alu_a_q;
  assign o_alu_b    = alu_b_q;
  assign o_alu_op   = alu_op_q;
  assign o_tx_start = tx_start_q;
  assign o_tx_data  = tx_data_q;
  assign o_busy     = (state_q != StIdleA);
  assign o_overrun  = overrun_q;
  assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Self-checking bench for alu_uart_ctrl.
// A frame-level model predicts every output and is compared on each falling edge.
// Directed literal checks pin the model to hand-computed values.

module tb_alu_uart_ctrl;

  localparam int unsigned DW = 8;
  localparam int unsigned OW = 6;
  localparam int unsigned TT = 4;

  logic          i_clock = 1'b0;
  logic          i_reset = 1'b0;
  logic          i_tick = 1'b0;
  logic          i_rx_done = 1'b0;
  logic [DW-1:0] i_rx_data = '0;
  logic [DW-1:0] i_alu_result;
  logic          i_tx_done = 1'b0;
  logic [DW-1:0] o_alu_a, o_alu_b, o_tx_data;
  logic [OW-1:0] o_alu_op;
  logic          o_tx_start, o_busy, o_overrun, o_timeout;

  int checks = 0;
  int errors = 0;

  alu_uart_ctrl #(
    .DATA_WIDTH   (DW),
    .OP_WIDTH     (OW),
    .TIMEOUT_TICKS(TT)
  ) dut (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_tick      (i_tick),
    .i_rx_done   (i_rx_done),
    .i_rx_data   (i_rx_data),
    .i_alu_result(i_alu_result),
    .i_tx_done   (i_tx_done),
    .o_alu_a     (o_alu_a),
    .o_alu_b     (o_alu_b),
    .o_alu_op    (o_alu_op),
    .o_tx_start  (o_tx_start),
    .o_tx_data   (o_tx_data),
    .o_busy      (o_busy),
    .o_overrun   (o_overrun),
    .o_timeout   (o_timeout)
  );

  always #5 i_clock = ~i_clock;

  // Bench ALU: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, others 0.
  function automatic logic [DW-1:0] alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [OW-1:0] op);
    case (op)
      6'h20:   alu_fn = a + b;
      6'h22:   alu_fn = a - b;
      6'h24:   alu_fn = a & b;
      6'h25:   alu_fn = a | b;
      default: alu_fn = '0;
    endcase
  endfunction

  assign i_alu_result = alu_fn(o_alu_a, o_alu_b, o_alu_op);

  // ---------------- frame-level model ----------------
  logic [DW-1:0] m_a, m_b, m_data;
  logic [OW-1:0] m_op;
  int            m_nbytes;   // bytes of the current frame collected so far
  bit            m_settle;   // full frame received, result not yet launched
  bit            m_txing;    // result handed to the transmitter
  bit            m_start, m_overrun, m_timeout;
  int            m_ticks;

  task automatic model_reset();
    m_a = '0; m_b = '0; m_op = '0; m_data = '0;
    m_nbytes = 0; m_settle = 0; m_txing = 0;
    m_start = 0; m_overrun = 0; m_timeout = 0; m_ticks = 0;
  endtask

  always @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      model_reset();
    end else begin
      m_start   = 0;
      m_timeout = 0;
      if (m_txing) begin
        if (i_rx_done) m_overrun = 1;
        if (i_tx_done) m_txing = 0;
      end else if (m_settle) begin
        if (i_rx_done) m_overrun = 1;
        m_settle = 0;
        m_txing  = 1;
        m_start  = 1;
        m_data   = alu_fn(m_a, m_b, m_op);
      end else if (i_rx_done) begin
        m_ticks = 0;
        if (m_nbytes == 0) begin
          m_a = i_rx_data; m_nbytes = 1;
        end else if (m_nbytes == 1) begin
          m_b = i_rx_data; m_nbytes = 2;
        end else begin
          m_op = i_rx_data[OW-1:0]; m_nbytes = 0; m_settle = 1;
        end
      end else if (m_nbytes != 0) begin
`ifdef ALU_UART_TIMEOUT_EN
        if (i_tick) m_ticks++;
        if (m_ticks == TT) begin
          m_ticks = 0; m_nbytes = 0; m_timeout = 1;
        end
`endif
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  bit cmp_en = 0;

  always @(negedge i_clock) begin
    if (cmp_en) begin
      check("alu_a", 32'(o_alu_a), 32'(m_a));
      check("alu_b", 32'(o_alu_b), 32'(m_b));
      check("alu_op", 32'(o_alu_op), 32'(m_op));
      check("tx_start", 32'(o_tx_start), 32'(m_start));
      check("tx_data", 32'(o_tx_data), 32'(m_data));
      check("busy", 32'(o_busy), 32'(m_nbytes != 0 || m_settle || m_txing));
      check("overrun", 32'(o_overrun), 32'(m_overrun));
      check("timeout", 32'(o_timeout), 32'(m_timeout));
    end
  end

  // Hold the given inputs for one clock; returns 1 time unit after the edge.
  task automatic drive(input logic rx, input logic [DW-1:0] d, input logic txd, input logic tk);
    i_rx_done = rx; i_rx_data = d; i_tx_done = txd; i_tick = tk;
    @(posedge i_clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    #1;
    check("rst_a", 32'(o_alu_a), 0);
    check("rst_tx_data", 32'(o_tx_data), 0);
    check("rst_busy", 32'(o_busy), 0);
    check("rst_overrun", 32'(o_overrun), 0);
    @(posedge i_clock);
    #1;
    i_reset = 1'b0;
  endtask

  initial begin
    model_reset();
    @(posedge i_clock);
    #1;
    do_reset();
    cmp_en = 1;
    idle(2);

    // Frame 05 03 20: tx_start must appear two cycles after the op byte cycle.
    drive(1'b1, 8'h05, 1'b0, 1'b0);
    drive(1'b1, 8'h03, 1'b0, 1'b0);
    drive(1'b1, 8'h20, 1'b0, 1'b0);
    check("lit_send_no_start", 32'(o_tx_start), 0);
    check("lit_op_20", 32'(o_alu_op), 32'h20);
    idle(1);
    check("lit_start", 32'(o_tx_start), 1);
    check("lit_data_08", 32'(o_tx_data), 32'h08);
    check("lit_a_05", 32'(o_alu_a), 32'h05);
    check("lit_b_03", 32'(o_alu_b), 32'h03);
    idle(1);
    check("lit_start_once", 32'(o_tx_start), 0);
    // Extra byte while transmitting: overrun, frame untouched.
    drive(1'b1, 8'hAA, 1'b0, 1'b0);
    check("lit_overrun", 32'(o_overrun), 1);
    check("lit_data_held", 32'(o_tx_data), 32'h08);
    idle(2);
    drive(1'b0, '0, 1'b1, 1'b0);
    check("lit_idle_after_tx", 32'(o_busy), 0);

    // tx_done outside WAIT_TX is ignored; op byte upper bits dropped (E2 -> 22, SUB).
    drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b1, 8'h09, 1'b0, 1'b0);
    drive(1'b1, 8'h04, 1'b1, 1'b0);
    drive(1'b1, 8'hE2, 1'b0, 1'b0);
    check("lit_op_22", 32'(o_alu_op), 32'h22);
    idle(1);
    check("lit_sub", 32'(o_tx_data), 32'h05);
    check("lit_overrun_sticky", 32'(o_overrun), 1);
    // rx in the same cycle as tx_done: ignored, overrun stays.
    drive(1'b1, 8'h55, 1'b1, 1'b0);
    check("lit_a_kept", 32'(o_alu_a), 32'h09);
    // Back-to-back: next byte the cycle after tx_done becomes A.
    drive(1'b1, 8'h0C, 1'b0, 1'b0);
    check("lit_b2b_a", 32'(o_alu_a), 32'h0C);
    drive(1'b1, 8'h0A, 1'b0, 1'b0);
    drive(1'b1, 8'h24, 1'b0, 1'b0);
    idle(1);
    check("lit_and", 32'(o_tx_data), 32'h08);
    idle(1);
    drive(1'b0, '0, 1'b1, 1'b0);

    // Reset in WAIT_OP, then a normal frame (OR).
    drive(1'b1, 8'h11, 1'b0, 1'b0);
    drive(1'b1, 8'h22, 1'b0, 1'b0);
    do_reset();
    check("lit_rst_op", 32'(o_alu_op), 0);
    drive(1'b1, 8'h30, 1'b0, 1'b0);
    drive(1'b1, 8'h03, 1'b0, 1'b0);
    drive(1'b1, 8'h25, 1'b0, 1'b0);
    idle(1);
    check("lit_or", 32'(o_tx_data), 32'h33);
    check("lit_no_overrun", 32'(o_overrun), 0);
    drive(1'b0, '0, 1'b1, 1'b0);

    // Inter-byte timeout: byte 05 then four ticks.
    drive(1'b1, 8'h05, 1'b0, 1'b0);
    for (int i = 0; i < int'(TT); i++) begin
      drive(1'b0, '0, 1'b0, 1'b1);
`ifdef ALU_UART_TIMEOUT_EN
      check("lit_to_pulse", 32'(o_timeout), 32'(i == int'(TT) - 1));
`else
      check("lit_no_to", 32'(o_timeout), 0);
`endif
    end
    idle(1);
`ifdef ALU_UART_TIMEOUT_EN
    check("lit_to_idle", 32'(o_busy), 0);
`else
    check("lit_to_wait", 32'(o_busy), 1);
`endif
    check("lit_to_keep_a", 32'(o_alu_a), 32'h05);
    idle(2);
    do_reset();
    idle(2);

    cmp_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/alu_uart_ctrl.md
ALU_UART_CTRL -- requirements
Module: alu_uart_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of operand, result and UART data bytes.
REQ-002 SHALL have parameter OP_WIDTH, default 6, width of ALU opcode, taken from the LSBs of the received op byte.
REQ-003 SHALL have parameter TIMEOUT_TICKS, default 2560, count of i_tick pulses allowed between consecutive frame bytes.
REQ-004 SHALL have one clock and an asynchronous, active-high reset.
REQ-005 i_clock  input  1  system clock; all state changes on the rising edge.
REQ-006 i_reset  input  1  asynchronous, active-high reset.
REQ-007 i_tick  input  1  baud-rate tick from the baud generator, one i_clock cycle wide.
REQ-008 i_rx_done  input  1  UART receiver byte-complete pulse, one cycle wide.
REQ-009 i_rx_data  input  DATA_WIDTH  received byte, valid while i_rx_done=1.
REQ-010 i_alu_result  input  DATA_WIDTH  combinational ALU result.
REQ-011 i_tx_done  input  1  UART transmitter frame-complete pulse.
REQ-012 o_alu_a  output  DATA_WIDTH  registered operand A.
REQ-013 o_alu_b  output  DATA_WIDTH  registered operand B.
REQ-014 o_alu_op  output  OP_WIDTH  registered opcode.
REQ-015 o_tx_start  output  1  one-cycle transmit request.
REQ-016 o_tx_data  output  DATA_WIDTH  byte to transmit, stable from o_tx_start until i_tx_done.
REQ-017 o_busy  output  1  high in every state except IDLE_A.
REQ-018 o_overrun  output  1  sticky flag, byte received while not accepting.
REQ-019 o_timeout  output  1  one-cycle pulse on inter-byte timeout.

Function
REQ-020 SHALL implement FSM states IDLE_A, WAIT_B, WAIT_OP, SEND, WAIT_TX.
REQ-021 IDLE_A: on i_rx_done, o_alu_a <= i_rx_data, go WAIT_B.
REQ-022 WAIT_B: on i_rx_done, o_alu_b <= i_rx_data, go WAIT_OP.
REQ-023 WAIT_OP: on i_rx_done, o_alu_op <= i_rx_data[OP_WIDTH-1:0], go SEND; upper bits discarded.
REQ-024 SEND lasts exactly one cycle (ALU settle); at its closing edge o_tx_data <= i_alu_result, o_tx_start <= 1, go WAIT_TX.
REQ-025 o_tx_start SHALL be high exactly one cycle, the first cycle of WAIT_TX; latency op-byte i_rx_done edge to o_tx_start high = 2 cycles.
REQ-026 WAIT_TX: on i_tx_done go IDLE_A; o_tx_data held until then.
REQ-027 i_rx_done in SEND or WAIT_TX (including same cycle as i_tx_done) SHALL be ignored and set o_overrun.
REQ-028 o_alu_a/b/op SHALL hold their values until overwritten by a new frame.
REQ-029 i_tx_done outside WAIT_TX SHALL be ignored.

Reset
REQ-030 Reset SHALL force state IDLE_A, all outputs 0, timeout counter 0, from any state including mid-frame and mid-transmit.

Configuration
REQ-031 Macro ALU_UART_TIMEOUT_EN defined: in WAIT_B/WAIT_OP a counter increments on i_tick, clears on i_rx_done; on reaching TIMEOUT_TICKS go IDLE_A, pulse o_timeout one cycle, keep captured registers.
REQ-032 Macro undefined: no counter, FSM waits indefinitely, o_timeout tied 0, i_tick unused.

Verification
REQ-033 Bytes 0x05, 0x03, 0x20 (bench ALU 0x20=ADD) -> o_alu_a=0x05, o_alu_b=0x03, o_alu_op=0x20, o_tx_start pulse 2 cycles after third i_rx_done, o_tx_data=0x08.
REQ-034 Op byte 0xE2 -> o_alu_op=0x22 (upper bits dropped).
REQ-035 Extra byte 0xAA during WAIT_TX -> o_overrun=1, frame unaffected, o_overrun cleared only by i_reset.
REQ-036 i_reset pulse while in WAIT_OP -> IDLE_A, all outputs 0; next 3-byte frame processed normally.
REQ-037 With ALU_UART_TIMEOUT_EN, TIMEOUT_TICKS=4: byte 0x05 then 4 ticks idle -> o_timeout pulse, o_busy=0; without macro same stimulus -> stays WAIT_B.
REQ-038 Back-to-back frames: second frame's first byte arriving the cycle after i_tx_done -> captured as A.
